// File: rtl/image_pkg.sv
// Shared definitions for the image downsampler front end.
//   - default geometry and pixel/index widths
//   - frame-tracking state enum
//   - log2 helper for power-of-two downsample factors
package image_pkg;

  localparam int unsigned GRAY_WIDTH_DEFAULT   = 8;
  localparam int unsigned WEIGHTS_ADDR_DEFAULT = 10;
  localparam int unsigned IN_WIDTH_DEFAULT     = 112;
  localparam int unsigned IN_HEIGHT_DEFAULT    = 112;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } ds_state_e;

  // Exact log2 for powers of two (ceil for anything else).
  function automatic int unsigned ds_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/block_accumulator.sv
// Line buffer of per-block partial sums plus load/add/mean datapath.
// Ports:
//   pclk     pixel clock
//   wr_en    accept pixel_in into entry blk this cycle
//   load     first pixel of a block: entry is overwritten instead of added to
//   blk      block (output column) index
//   pixel_in input grayscale pixel
//   mean     (entry + pixel_in) >> SHIFT, i.e. block mean when this is the final pixel
module block_accumulator #(
  parameter int unsigned OUT_W      = 28,
  parameter int unsigned GRAY_WIDTH = 8,
  parameter int unsigned SHIFT      = 4,
  parameter int unsigned BLK_W      = 5
) (
  input  logic                  pclk,
  input  logic                  wr_en,
  input  logic                  load,
  input  logic [BLK_W-1:0]      blk,
  input  logic [GRAY_WIDTH-1:0] pixel_in,
  output logic [GRAY_WIDTH-1:0] mean
);

  localparam int unsigned ACC_W = GRAY_WIDTH + SHIFT;

  // No reset: every entry is loaded by the first pixel of its block before use.
  logic [ACC_W-1:0] acc_q [OUT_W];
  logic [ACC_W-1:0] sum;

  always_comb begin
    sum = ACC_W'(pixel_in);
    if (!load) sum = acc_q[blk] + ACC_W'(pixel_in);
  end

  always_ff @(posedge pclk) begin
    if (wr_en) acc_q[blk] <= sum;
  end

  // Upper GRAY_WIDTH bits of the sum are the truncated mean.
  assign mean = sum[ACC_W-1:SHIFT];

endmodule

// File: rtl/image_downsampler.sv
// Block-mean image downsampler feeding the digit classifier.
// Each DS_X x DS_Y block of a de-qualified raster frame (started by vsync) becomes one
// output pixel, emitted one cycle after the block's final input pixel with a row-major
// index. classification_en marks the last output pixel of a complete frame; frame_err
// pulses when vsync arrives mid-frame.
// Ports:
//   pclk, rst (synchronous, active low)
//   vsync, de, pixel_in                         input stream
//   pixel_valid, pixel_out, pixel_index_out     output pixel stream
//   classification_en, frame_err                frame status pulses
// Build option: define IMAGE_DOWNSAMPLER_BINARIZE_EN to output (mean > GRAY_THRESHOLD)
// instead of the grayscale mean.
module image_downsampler
  import image_pkg::*;
#(
  parameter int unsigned IN_WIDTH       = IN_WIDTH_DEFAULT,
  parameter int unsigned IN_HEIGHT      = IN_HEIGHT_DEFAULT,
  parameter int unsigned DS_X           = 4,
  parameter int unsigned DS_Y           = 4,
  parameter int unsigned GRAY_WIDTH     = GRAY_WIDTH_DEFAULT,
  parameter int unsigned GRAY_THRESHOLD = 128,
  parameter int unsigned WEIGHTS_ADDR   = WEIGHTS_ADDR_DEFAULT
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    vsync,
  input  logic                    de,
  input  logic [GRAY_WIDTH-1:0]   pixel_in,
  output logic                    pixel_valid,
  output logic [GRAY_WIDTH-1:0]   pixel_out,
  output logic [WEIGHTS_ADDR-1:0] pixel_index_out,
  output logic                    classification_en,
  output logic                    frame_err
);

  localparam int unsigned OUT_W      = IN_WIDTH / DS_X;
  localparam int unsigned OUT_H      = IN_HEIGHT / DS_Y;
  localparam int unsigned OUT_PIXELS = OUT_W * OUT_H;
  localparam int unsigned SHX        = ds_log2(DS_X);
  localparam int unsigned SHY        = ds_log2(DS_Y);
  localparam int unsigned CW         = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned RW         = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned BLK_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [CW-1:0]           SX_MASK  = CW'(DS_X - 1);
  localparam logic [RW-1:0]           SY_MASK  = RW'(DS_Y - 1);
  localparam logic [CW-1:0]           COL_MAX  = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0]           ROW_MAX  = RW'(IN_HEIGHT - 1);
  localparam logic [WEIGHTS_ADDR-1:0] IDX_LAST = WEIGHTS_ADDR'(OUT_PIXELS - 1);
  localparam logic [GRAY_WIDTH-1:0]   THRESH   = GRAY_WIDTH'(GRAY_THRESHOLD);

  ds_state_e state_q, state_d;

  logic [CW-1:0]           col_q, col_eff;
  logic [RW-1:0]           row_q, row_eff;
  logic [WEIGHTS_ADDR-1:0] idx_q, idx_eff;
  logic                    beat, col_last, row_last, frame_last;
  logic                    blk_first, blk_done;
  logic                    emit, err_pulse;
  logic [BLK_W-1:0]        blk;
  logic [GRAY_WIDTH-1:0]   mean, pix_d;

  // vsync restarts the frame in the same cycle, so a coincident de beat is pixel (0,0).
  assign col_eff = vsync ? '0 : col_q;
  assign row_eff = vsync ? '0 : row_q;
  assign idx_eff = vsync ? '0 : idx_q;

  assign beat       = de & (vsync | (state_q == StActive));
  assign col_last   = (col_eff == COL_MAX);
  assign row_last   = (row_eff == ROW_MAX);
  assign frame_last = beat & col_last & row_last;
  assign blk_first  = ((col_eff & SX_MASK) == '0) & ((row_eff & SY_MASK) == '0);
  assign blk_done   = ((col_eff & SX_MASK) == SX_MASK) & ((row_eff & SY_MASK) == SY_MASK);
  assign blk        = BLK_W'(col_eff >> SHX);

  // State register
  always_ff @(posedge pclk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (vsync) state_d = StActive;
      StActive: if (frame_last) state_d = StDone;
      StDone:   if (vsync) state_d = StActive;
      default:  state_d = StIdle;
    endcase
    // Degenerate single-pixel frame: the vsync beat is also the last beat.
    if (vsync && frame_last) state_d = StDone;
  end

  // FSM outputs
  always_comb begin
    emit      = beat & blk_done;
    err_pulse = vsync & (state_q == StActive);
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      idx_q <= '0;
    end else begin
      if (beat) begin
        col_q <= col_last ? '0 : col_eff + 1'b1;
        if (col_last) row_q <= row_last ? '0 : row_eff + 1'b1;
        else          row_q <= row_eff;
      end else if (vsync) begin
        col_q <= '0;
        row_q <= '0;
      end
      if (emit)       idx_q <= idx_eff + 1'b1;
      else if (vsync) idx_q <= '0;
    end
  end

  block_accumulator #(
    .OUT_W      (OUT_W),
    .GRAY_WIDTH (GRAY_WIDTH),
    .SHIFT      (SHX + SHY),
    .BLK_W      (BLK_W)
  ) u_block_accumulator (
    .pclk     (pclk),
    .wr_en    (beat),
    .load     (blk_first),
    .blk      (blk),
    .pixel_in (pixel_in),
    .mean     (mean)
  );

`ifdef IMAGE_DOWNSAMPLER_BINARIZE_EN
  assign pix_d = GRAY_WIDTH'(mean > THRESH);
`else
  // Threshold is only meaningful in the binarising build.
  logic unused_thresh;
  assign unused_thresh = ^THRESH;
  assign pix_d = mean;
`endif

  always_ff @(posedge pclk) begin
    if (!rst) begin
      pixel_valid       <= 1'b0;
      pixel_out         <= '0;
      pixel_index_out   <= '0;
      classification_en <= 1'b0;
      frame_err         <= 1'b0;
    end else begin
      pixel_valid       <= emit;
      classification_en <= emit & (idx_eff == IDX_LAST);
      frame_err         <= err_pulse;
      if (emit) begin
        pixel_out       <= pix_d;
        pixel_index_out <= idx_eff;
      end
    end
  end

endmodule

// File: tb/tb_image_downsampler.sv
module tb_image_downsampler;

  localparam int W = 112;
  localparam int H = 112;
  localparam int NPIX = W * H;
  localparam int OUTW = 28;
  localparam int NOUT = 784;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vsync;
  logic       de;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic [7:0] pixel_out;
  logic [9:0] pixel_index_out;
  logic       classification_en;
  logic       frame_err;

  image_downsampler dut (
    .pclk              (pclk),
    .rst               (rst),
    .vsync             (vsync),
    .de                (de),
    .pixel_in          (pixel_in),
    .pixel_valid       (pixel_valid),
    .pixel_out         (pixel_out),
    .pixel_index_out   (pixel_index_out),
    .classification_en (classification_en),
    .frame_err         (frame_err)
  );

  always #5 pclk = ~pclk;

  int ntot = 0;
  int nbad = 0;

  // Expectations for the outputs registered at the next rising edge.
  bit pv_valid, pv_cls, pv_err;
  int pv_pix, pv_idx;
  int hold_pix, hold_idx;
  // Bench view of frame position.
  bit bactive;
  int bcol, brow, cur_kind;
  // Observed DUT pulse counts.
  int n_valid, n_cls, n_err;

  task automatic check(input string tag, input int obs, input int exp);
    ntot++;
    if (obs != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // kinds: 0 uniform 200, 1 col%4 gradient, 2 threshold-edge blocks, 3 row+col ramp, 4 uniform 50
  function automatic logic [7:0] pix_fn(input int kind, input int c, input int r);
    case (kind)
      0: return 8'd200;
      1: return 8'(c % 4);
      2: if ((c / 4) % 2 == 0) return ((c % 4) < 2) ? 8'd127 : 8'd129;
         else                  return ((c % 4) < 2) ? 8'd128 : 8'd130;
      3: return 8'(r + c);
      default: return 8'd50;
    endcase
  endfunction

  // Hand-derived block means: gradient (0+1+2+3)*4/16 = 1; threshold blocks
  // 8*127+8*129 = 2048 -> 128 and 8*128+8*130 = 2064 -> 129; ramp 4*(ox+oy)+48/16.
  function automatic int exp_mean(input int kind, input int ox, input int oy);
    case (kind)
      0: return 200;
      1: return 1;
      2: return (ox % 2 == 0) ? 128 : 129;
      3: return 4 * (ox + oy) + 3;
      default: return 50;
    endcase
  endfunction

  function automatic int exp_out(input int m);
`ifdef IMAGE_DOWNSAMPLER_BINARIZE_EN
    return (m > 128) ? 1 : 0;
`else
    return m;
`endif
  endfunction

  task automatic observe();
    @(negedge pclk);
    if (pv_valid) begin
      hold_pix = pv_pix;
      hold_idx = pv_idx;
    end
    check("valid", int'(pixel_valid), int'(pv_valid));
    check("class_en", int'(classification_en), int'(pv_cls));
    check("frame_err", int'(frame_err), int'(pv_err));
    check("pixel_out", int'(pixel_out), hold_pix);
    check("index", int'(pixel_index_out), hold_idx);
    if (pixel_valid) n_valid++;
    if (classification_en) n_cls++;
    if (frame_err) n_err++;
  endtask

  task automatic beat(input bit vs, input bit d);
    logic [7:0] p;
    observe();
    pv_valid = 1'b0;
    pv_cls   = 1'b0;
    pv_err   = 1'b0;
    if (vs) begin
      pv_err  = bactive;
      bactive = 1'b1;
      bcol    = 0;
      brow    = 0;
    end
    p = pix_fn(cur_kind, bcol, brow);
    if (d && bactive) begin
      if ((bcol % 4 == 3) && (brow % 4 == 3)) begin
        pv_valid = 1'b1;
        pv_idx   = (brow / 4) * OUTW + bcol / 4;
        pv_pix   = exp_out(exp_mean(cur_kind, bcol / 4, brow / 4));
        pv_cls   = (pv_idx == NOUT - 1);
      end
      if (bcol == W - 1) begin
        bcol = 0;
        if (brow == H - 1) bactive = 1'b0;
        else brow++;
      end else begin
        bcol++;
      end
    end
    rst      = 1'b1;
    vsync    = vs;
    de       = d;
    pixel_in = p;
  endtask

  task automatic do_reset();
    observe();
    rst      = 1'b0;
    vsync    = 1'b0;
    de       = 1'b0;
    pixel_in = 8'd0;
    pv_valid = 1'b0;
    pv_cls   = 1'b0;
    pv_err   = 1'b0;
    hold_pix = 0;
    hold_idx = 0;
    bactive  = 1'b0;
  endtask

  // Stream npix pixels of a frame; vs_first puts vsync on the first de beat.
  task automatic frame(input int kind, input int npix, input bit gaps, input bit vs_first);
    cur_kind = kind;
    n_valid  = 0;
    n_cls    = 0;
    n_err    = 0;
    if (!vs_first) beat(1'b1, 1'b0);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(15) == 0) begin
        int g;
        g = $urandom_range(20);
        repeat (g) beat(1'b0, 1'b0);
      end
      beat(vs_first && (i == 0), 1'b1);
    end
  endtask

  task automatic flush();
    repeat (3) beat(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    vsync = 1'b0;
    de = 1'b0;
    pixel_in = 8'd0;
    pv_valid = 0; pv_cls = 0; pv_err = 0; pv_pix = 0; pv_idx = 0;
    hold_pix = 0; hold_idx = 0; bactive = 0; bcol = 0; brow = 0; cur_kind = 0;
    n_valid = 0; n_cls = 0; n_err = 0;
    repeat (2) @(posedge pclk);
    do_reset();
    do_reset();

    // Idle: de without vsync is ignored.
    repeat (20) beat(1'b0, 1'b1);
    check("idle_valids", n_valid, 0);

    // Uniform frame, then de beats in DONE that must be ignored.
    frame(0, NPIX, 1'b0, 1'b0);
    flush();
    check("uni_valids", n_valid, NOUT);
    check("uni_cls", n_cls, 1);
    n_valid = 0;
    repeat (40) beat(1'b0, 1'b1);
    check("done_valids", n_valid, 0);

    // Gradient with blanking gaps.
    frame(1, NPIX, 1'b1, 1'b0);
    flush();
    check("grad_valids", n_valid, NOUT);
    check("grad_cls", n_cls, 1);

    // Threshold-edge means 128/129.
    frame(2, NPIX, 1'b0, 1'b0);
    flush();
    check("thr_valids", n_valid, NOUT);
    check("thr_cls", n_cls, 1);

    // Abort at pixel 5000: 11 block rows of 28 completed, no classification.
    frame(4, 5000, 1'b0, 1'b0);
    check("abort_valids", n_valid, 308);
    check("abort_cls", n_cls, 0);
    // vsync coincides with de: that beat is pixel (0,0) of the ramp frame.
    frame(3, NPIX, 1'b1, 1'b1);
    flush();
    check("abort_err", n_err, 1);
    check("ramp_valids", n_valid, NOUT);
    check("ramp_cls", n_cls, 1);

    // Reset mid-frame, de ignored until vsync, then a clean frame.
    frame(0, 3000, 1'b0, 1'b0);
    do_reset();
    n_valid = 0;
    n_err   = 0;
    repeat (30) beat(1'b0, 1'b1);
    check("post_rst_valids", n_valid, 0);
    frame(2, NPIX, 1'b0, 1'b0);
    flush();
    check("rst_err", n_err, 0);
    check("rst_valids", n_valid, NOUT);
    check("rst_cls", n_cls, 1);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule

// File: doc/image_downsampler.md
# image_downsampler

Parametrised front end for the handwritten-digit classifier. It takes a raster camera stream (`de` qualified, frame start on `vsync`) and reduces each DS_X×DS_Y block of input pixels to one output pixel by block mean. In binarise mode it also applies a threshold. The block emits pixels with a row-major weight index and flags the last pixel of each frame to start classification. It sits between the camera/grayscale stage and the neural-network weight-MAC stage.

## Interface
- IN_WIDTH, 112: active pixels per input line
- IN_HEIGHT, 112: active lines per input frame
- DS_X, 4: horizontal downsample factor; power of two, divides IN_WIDTH
- DS_Y, 4: vertical downsample factor; power of two, divides IN_HEIGHT
- GRAY_WIDTH, 8: input/output pixel width
- GRAY_THRESHOLD, 128: binarisation threshold
- WEIGHTS_ADDR, 10: index width; must hold OUT_PIXELS-1

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset
- vsync  in  1  one-cycle frame-start pulse
- de  in  1  input pixel valid
- pixel_in  in  GRAY_WIDTH  input grayscale pixel
- pixel_valid  out  1  pixel_out/pixel_index_out valid this cycle
- pixel_out  out  GRAY_WIDTH  downsampled pixel
- pixel_index_out  out  WEIGHTS_ADDR  row-major output index, 0..OUT_PIXELS-1
- classification_en  out  1  one-cycle pulse coincident with last pixel of frame
- frame_err  out  1  one-cycle pulse: frame aborted by early vsync

## Operation
- Derived values:
  - OUT_W = IN_WIDTH/DS_X
  - OUT_H = IN_HEIGHT/DS_Y
  - OUT_PIXELS = OUT_W·OUT_H
  - ACC_W = GRAY_WIDTH + log2(DS_X·DS_Y)
- States:
  - IDLE: wait for vsync.
  - ACTIVE: count and accumulate.
  - DONE: ignore `de` until vsync.
- Transitions:
  - IDLE→ACTIVE on vsync.
  - ACTIVE→DONE on the `de` beat that is pixel (IN_WIDTH-1, IN_HEIGHT-1).
  - DONE→ACTIVE on vsync.
- Counters, advancing only on `de` in ACTIVE:
  - col 0..IN_WIDTH-1; on wrap, row increments.
  - row 0..IN_HEIGHT-1.
  - sub_x = col mod DS_X; sub_y = row mod DS_Y; blk = col/DS_X.
  - Gaps in `de` (blanking) hold all counters.
- Accumulator line buffer: OUT_W entries of ACC_W bits.
  - First pixel of a block (sub_x=0, sub_y=0): acc[blk] loads pixel_in.
  - Otherwise: acc[blk] += pixel_in.
  - No overflow is possible by ACC_W sizing.
- Block completion: sub_x=DS_X-1 and sub_y=DS_Y-1.
  - mean = (acc[blk]+pixel_in) >> log2(DS_X·DS_Y), truncating.
  - Emit an output pixel.
  - Output index increments by one per emitted pixel.
- vsync while in ACTIVE:
  - Pulse frame_err.
  - Clear counters and output index; restart ACTIVE.
  - Accumulators need no clear (first-pixel load).
- vsync and `de` in the same cycle: vsync wins; that `de` beat is pixel (0,0) of the new frame.
- Reset values:
  - all outputs 0, state IDLE
  - counters and output index 0

## Timing
- Latency: an output pixel is registered one cycle after the `de` beat carrying the block's final input pixel.
- pixel_valid is high that one cycle only.
- pixel_out and pixel_index_out hold their values until the next valid.
- classification_en is high in the same cycle as pixel_valid with pixel_index_out=OUT_PIXELS-1. It never fires on an aborted frame.
- Throughput: one input pixel per clock sustained, no back-pressure; output rate ≤ 1/DS_X of input.
- Reset is synchronous: a low `rst` on any edge returns to IDLE; a partial frame is discarded silently (no frame_err).

## Configuration
- Macro IMAGE_DOWNSAMPLER_BINARIZE_EN:
  - Defined: pixel_out = (mean > GRAY_THRESHOLD) ? 1 : 0, zero-extended to GRAY_WIDTH. This matches the binary input of the current network.
  - Undefined: pixel_out = mean, full grayscale. The threshold comparator is not built.

## Structure
- Shared package `image_pkg`:
  - GRAY_WIDTH default, WEIGHTS_ADDR default, IN_WIDTH/IN_HEIGHT defaults
  - state enum (IDLE/ACTIVE/DONE)
  - log2 helper for DS factors
- Sub-module `block_accumulator`: OUT_W-entry line buffer plus add/load/mean. The top level owns the FSM, counters and output registers.

## Test plan
- Uniform frame: 112×112, all pixels 200, binarise on → 784 valids, all pixel_out=1, indices 0..783, classification_en with index 783 only.
- Gradient: pixel = col within each 4×4 block (values 0..3 repeating), macro off → every pixel_out=1 (mean 1.5 truncates).
- Threshold edge, macro on: block mean exactly 128 → pixel_out=0; mean 129 → pixel_out=1.
- Blanking: random `de` gaps of 0–20 cycles → outputs identical to the gapless run; each valid is 1 cycle after the completing `de`.
- Early vsync at input pixel 5000 → frame_err pulse, no classification_en. The next full frame yields indices 0..783 and correct means.
- Reset mid-frame: rst low 1 cycle at pixel 3000 → all outputs 0. `de` is ignored until vsync; the next frame is correct.
